// File: rtl/avg8_sample_gather.sv
// avg8_sample_gather: gathers serial signed samples into frames of 8 for the averager.
// Define AVG8_SAMPLE_GATHER_SLIDING_EN for sliding-window (moving average) mode.
module avg8_sample_gather #(
    parameter int DATAW = 16,
    parameter int SAW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DATAW-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [SAW-1:0]   sa_cfg,
    input  logic                    out_ready,
    output logic signed [DATAW-1:0] a,
    output logic signed [DATAW-1:0] b,
    output logic signed [DATAW-1:0] c,
    output logic signed [DATAW-1:0] d,
    output logic signed [DATAW-1:0] e,
    output logic signed [DATAW-1:0] f,
    output logic signed [DATAW-1:0] g,
    output logic signed [DATAW-1:0] h,
    output logic signed [SAW-1:0]   sa,
    output logic                    out_valid
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              count;
    logic [DATAW-1:0]        shadow     [8];
    logic [DATAW-1:0]        frame_next [8];
    logic                    accept;
    logic                    last;
    logic                    xfer;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;

`ifdef AVG8_SAMPLE_GATHER_SLIDING_EN
    logic primed;

    // Once eight samples have been seen, every new sample completes a window.
    assign last = primed || (count == 3'd7);

    // Shadow acts as a shift register: oldest drops out of a, newest enters h.
    always_comb begin
        for (int i = 0; i < 8; i++) frame_next[i] = shadow[i];
        if (accept) begin
            for (int i = 0; i < 7; i++) frame_next[i] = shadow[i+1];
            frame_next[7] = in_data;
        end
    end

    // Primed flag: set by the eighth accept after reset, then sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= 1'b0;
        end else if (accept && count == 3'd7) begin
            primed <= 1'b1;
        end
    end
`else
    assign last = (count == 3'd7);

    // Shadow is written in arrival order, indexed by count.
    always_comb begin
        for (int i = 0; i < 8; i++) frame_next[i] = shadow[i];
        if (accept) frame_next[count] = in_data;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    // Next state and transfer decision.
    always_comb begin
        state_next = state;
        xfer       = 1'b0;
        unique case (state)
            FILL: begin
                if (accept && last) begin
                    if (out_ready) xfer = 1'b1;
                    else           state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    xfer       = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Shadow buffer and slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 3'd0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) shadow[i] <= frame_next[i];
            if (xfer)        count <= 3'd0;
            else if (accept) count <= count + 3'd1;
        end
    end

    // Output frame registers; the incoming h is taken from frame_next on a same-edge transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            g         <= '0;
            h         <= '0;
            sa        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                a  <= frame_next[0];
                b  <= frame_next[1];
                c  <= frame_next[2];
                d  <= frame_next[3];
                e  <= frame_next[4];
                f  <= frame_next[5];
                g  <= frame_next[6];
                h  <= frame_next[7];
                sa <= sa_cfg;
            end
        end
    end

endmodule

// File: tb/tb_avg8_sample_gather.sv
// tb_avg8_sample_gather: directed and randomized checks against a queue-based model.
// Honours AVG8_SAMPLE_GATHER_SLIDING_EN to switch the model to sliding windows.
module tb_avg8_sample_gather;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [7:0]  sa_cfg = '0;
    logic               out_ready = 1'b0;
    logic signed [15:0] a, b, c, d, e, f, g, h;
    logic signed [7:0]  sa;
    logic               out_valid;
    logic [15:0]        dout [8];

    int errs   = 0;
    int checks = 0;

    logic [15:0] win [$];
    bit          full;
    logic [15:0] m_out [8];
    logic [7:0]  m_sa;
    bit          m_ov;

    avg8_sample_gather dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sa_cfg(sa_cfg), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .sa(sa), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    assign dout[0] = a;
    assign dout[1] = b;
    assign dout[2] = c;
    assign dout[3] = d;
    assign dout[4] = e;
    assign dout[5] = f;
    assign dout[6] = g;
    assign dout[7] = h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        win.delete();
        full = 0;
        for (int i = 0; i < 8; i++) m_out[i] = '0;
        m_sa = '0;
        m_ov = 0;
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_slot%0d", tag, i), {16'd0, dout[i]}, {16'd0, m_out[i]});
        chk({tag, "_sa"}, {24'd0, sa}, {24'd0, m_sa});
        chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, m_ov});
    endtask

    // One clock: drive at negedge, predict, check after the rising edge.
    task automatic step(input logic v, input logic [15:0] dat,
                        input logic ordy, input logic [7:0] s);
        bit xfer;
        xfer = 0;
        in_valid  = v;
        in_data   = dat;
        out_ready = ordy;
        sa_cfg    = s;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !full});
        if (full) begin
            if (ordy) xfer = 1;
        end else if (v) begin
            win.push_back(dat);
            if (win.size() > 8) void'(win.pop_front());
            if (win.size() == 8) begin
                if (ordy) xfer = 1;
                else      full = 1;
            end
        end
        if (xfer) begin
            for (int i = 0; i < 8; i++) m_out[i] = win[i];
            m_sa = s;
            full = 0;
`ifndef AVG8_SAMPLE_GATHER_SLIDING_EN
            win.delete();
`endif
        end
        m_ov = xfer;
        @(posedge clk);
        #1;
        check_outs("step");
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] pat [8];
        int sum;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("reset");

        // Idle after reset.
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 8'h0);

        // Straight stream of small values.
`ifdef AVG8_SAMPLE_GATHER_SLIDING_EN
        for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b1, 8'd1);
        chk("slide_a", {16'd0, a}, 32'd3);
        chk("slide_h", {16'd0, h}, 32'd10);
`else
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1, 8'd1);
        sum = int'(a) + int'(b) + int'(c) + int'(d) + int'(e) + int'(f) + int'(g) + int'(h);
        chk("sum36", sum, 32'd36);
`endif
        step(1'b0, 16'h0, 1'b1, 8'd0);

        // Signed extremes with downstream stalled, then a held sample.
        pat = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001,
                16'hFFFE, 16'h0002, 16'hFFFD, 16'h0003};
        for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 8'd5);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h7FFF, 1'b0, 8'd5);
        step(1'b1, 16'h7FFF, 1'b1, 8'hFD);
        chk("sa_at_xfer", {24'd0, sa}, 32'h0000_00FD);
        step(1'b1, 16'h7FFF, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 16'(100 + i), 1'b1, 8'd2);
`ifndef AVG8_SAMPLE_GATHER_SLIDING_EN
        chk("held_in_slot_a", {16'd0, a}, 32'h0000_7FFF);
`endif

        // Reset part way through a frame.
        for (int i = 0; i < 5; i++) step(1'b1, 16'(50 + i), 1'b0, 8'd0);
        rst = 1'b1;
        #1;
        m_reset();
        check_outs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 16'(10 + i), 1'b1, 8'd4);
        chk("post_rst_a", {16'd0, a}, 32'd10);
        chk("post_rst_h", {16'd0, h}, 32'd17);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), 16'($urandom),
                 ($urandom_range(0, 2) != 0), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
